// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, reads words over req/ack,
// buffers {pc, word} pairs and hands the head to the core via valid/ready.
//
// Ports:
//   CLOCK_50, reset (async, active-low)
//   pause, redirect, redirect_pc       : control from the core
//   mem_req, mem_addr, mem_ack, mem_rdata : instruction memory handshake
//   inst_valid, inst_ready, instruction, inst_pc, pc_plus4 : head to core
//   queue_count                        : current occupancy
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     pause,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              instruction,
  output logic [31:0]              inst_pc,
  output logic [31:0]              pc_plus4,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t        fifo [DEPTH];
  entry_t        head;
  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [31:0]   fpc;
  logic [31:0]   fpc_nx;
  logic [31:0]   addr_q;
  logic [31:0]   addr_nx;
  logic          push;
  logic          pop;
  logic          hold;
  logic          go;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign head        = fifo[rptr];
  assign mem_req     = (state != IDLE);
  assign mem_addr    = addr_q;
  assign queue_count = count;
  assign inst_valid  = (count != '0) && !pause;
  assign instruction = (count != '0) ? head.word : 32'h0;
  assign inst_pc     = (count != '0) ? head.pc : 32'h0;
  assign pc_plus4    = inst_pc + 32'd4;

  // A redirect kills both the word acked this cycle and any pop.
  assign push = (state == REQ) && mem_ack && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;
  // Request still outstanding into next cycle: address must not move.
  assign hold = (state != IDLE) && !mem_ack;

  always_comb begin
    count_nx = count;
    if (push && !pop) begin
      count_nx = count + CW'(1);
    end else if (pop && !push) begin
      count_nx = count - CW'(1);
    end
    if (redirect) begin
      count_nx = '0;
    end
  end

  always_comb begin
    fpc_nx = fpc;
    if (redirect) begin
      fpc_nx = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fpc_nx = fpc + 32'd4;
    end
  end

  assign go      = !pause && (count_nx < FULL);
  assign addr_nx = hold ? addr_q : fpc_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!pause && (redirect || count < FULL)) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (!mem_ack) begin
          if (redirect) begin
            state_nx = DROP;
          end
        end else begin
          state_nx = go ? REQ : IDLE;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_nx = go ? REQ : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      addr_q <= RESET_PC;
      count  <= '0;
      rptr   <= '0;
      wptr   <= '0;
    end else begin
      state  <= state_nx;
      fpc    <= fpc_nx;
      addr_q <= addr_nx;
      count  <= count_nx;
      if (redirect) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + AW'(1);
        end
        if (pop) begin
          rptr <= rptr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else if (push) begin
      fifo[wptr] <= '{pc: fpc, word: mem_rdata};
    end
  end

endmodule
